// File: rtl/iic_slave_regbank.sv
// I2C slave register bank: DEPTH x 8 memory written/read over the bus, local read port, write-notify strobe.
// Latency: bus pins see 3 clk of sync delay; rd_data 1 clk after rd_addr; wr_valid 1 clk after the 8th data bit.
// Backpressure: none (no clock stretching); define IIC_SLAVE_TIMEOUT_EN to abort transfers stalled with SCL low.
module iic_slave_regbank #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         DEPTH       = 256,
  parameter int         AW          = 8,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          SCL,
  input  logic          SDA_in,
  output logic          SDA_out,
  output logic          SDA_oe,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, DEVADDR, ACK_DEV, REGADDR, ACK_REG, WRDATA, ACK_WR, RDDATA, RD_ACK
  } state_t;

  if (DEPTH < 2 || DEPTH > 256 || DEPTH > (1 << AW) || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("iic_slave_regbank: unsupported parameter combination");
  end

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_h, sda_h, scl_s, sda_s;
  logic          scl_rise, scl_fall, start_c, stop_c, timeout;
  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [7:0]    sh, sh_n;
  logic [AW-1:0] ptr, ptr_n, ptr_inc;
  logic          oe, oe_n, rw, rw_n, mack, mack_n;
  logic          bus_we;
  logic [7:0]    bus_dat, mem_ptr, mem_nxt;
  logic          clr_busy;
  logic [AW-1:0] clr_cnt;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdat;
  logic [7:0]    mem [DEPTH];

  // Two-flop synchronisers plus one history flop per bus line; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL};
      sda_sync <= {sda_sync[0], SDA_in};
      scl_h    <= scl_sync[1];
      sda_h    <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign start_c  = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_c   = scl_s & scl_h & ~sda_h & sda_s;

  assign ptr_inc  = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  assign mem_ptr  = mem[ptr];
  assign mem_nxt  = mem[ptr_inc];
  assign bus_dat  = {sh[6:0], sda_s};

`ifdef IIC_SLAVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  // Count clk cycles of SCL low inside a transfer; any SCL rise restarts the count.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || scl_rise) to_cnt <= '0;
    else if (!scl_s)                      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state != IDLE) && !scl_s && (to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // No stall watchdog: a transfer waits indefinitely while SCL is held low.
  assign timeout = 1'b0;
`endif

  // Next-state logic: START/STOP override everything; bits sampled on SCL rise, SDA_oe moved on SCL fall.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    ptr_n   = ptr;
    oe_n    = oe;
    rw_n    = rw;
    mack_n  = mack;
    bus_we  = 1'b0;
    if (clr_busy || stop_c || timeout) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else if (start_c) begin
      state_n = DEVADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
    end else begin
      unique case (state)
        DEVADDR, REGADDR, WRDATA: begin
          if (scl_rise && cnt != 4'd8) begin
            sh_n  = bus_dat;
            cnt_n = cnt + 4'd1;
            // Data byte commits on its 8th bit, before the ACK clock.
            if (state == WRDATA && cnt == 4'd7) bus_we = 1'b1;
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n = '0;
            if (state == DEVADDR) begin
              if (sh[7:1] == DEV_ADDR) begin
                state_n = ACK_DEV;
                oe_n    = 1'b1;
                rw_n    = sh[0];
              end else begin
                state_n = IDLE;
              end
            end else if (state == REGADDR) begin
              // Out-of-range pointer is refused and ptr keeps its last valid value.
              if ({1'b0, sh} < 9'(DEPTH)) begin
                ptr_n   = AW'(sh);
                state_n = ACK_REG;
                oe_n    = 1'b1;
              end else begin
                state_n = IDLE;
              end
            end else begin
              state_n = ACK_WR;
              oe_n    = 1'b1;
            end
          end
        end
        ACK_DEV: begin
          if (scl_fall) begin
            if (rw) begin
              state_n = RDDATA;
              sh_n    = mem_ptr;
              oe_n    = ~mem_ptr[7];
            end else begin
              state_n = REGADDR;
              oe_n    = 1'b0;
            end
          end
        end
        ACK_REG: begin
          if (scl_fall) begin
            state_n = WRDATA;
            oe_n    = 1'b0;
          end
        end
        ACK_WR: begin
          if (scl_fall) begin
            state_n = WRDATA;
            oe_n    = 1'b0;
            ptr_n   = ptr_inc;
          end
        end
        RDDATA: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              state_n = RD_ACK;
              oe_n    = 1'b0;
              cnt_n   = '0;
            end else begin
              sh_n = {sh[6:0], 1'b0};
              oe_n = ~sh[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            mack_n = ~sda_s;
          end else if (scl_fall) begin
            if (mack) begin
              ptr_n   = ptr_inc;
              sh_n    = mem_nxt;
              oe_n    = ~mem_nxt[7];
              state_n = RDDATA;
            end else begin
              state_n = IDLE;
              oe_n    = 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state, datapath registers and the write-notify strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      ptr      <= '0;
      oe       <= 1'b0;
      rw       <= 1'b0;
      mack     <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      ptr      <= ptr_n;
      oe       <= oe_n;
      rw       <= rw_n;
      mack     <= mack_n;
      wr_valid <= bus_we;
      if (bus_we) begin
        wr_addr <= ptr;
        wr_data <= bus_dat;
      end
    end
  end

  // Post-reset sweep that zeroes one memory word per clk; the bus is ignored meanwhile.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_busy <= 1'b1;
      clr_cnt  <= '0;
    end else if (clr_busy) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == AW'(DEPTH - 1)) clr_busy <= 1'b0;
    end
  end

  assign mem_we    = !rst && (clr_busy || bus_we);
  assign mem_waddr = clr_busy ? clr_cnt : ptr;
  assign mem_wdat  = clr_busy ? 8'h00 : bus_dat;

  // Single write port shared by the clear sweep and bus writes.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
  end

  // Local read port; a same-cycle write to the same address forwards the new value.
  always_ff @(posedge clk) begin
    if (rst)                                 rd_data <= '0;
    else if (mem_we && mem_waddr == rd_addr) rd_data <= mem_wdat;
    else                                     rd_data <= mem[rd_addr];
  end

  assign SDA_oe  = oe;
  assign SDA_out = 1'b0;

endmodule

// File: tb/tb_iic_slave_regbank.sv
`timescale 1ns/1ps
module tb_iic_slave_regbank;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst, scl_m, sda_m, sda_bus;
  logic          SDA_out, SDA_oe, wr_valid;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    rd_data, wr_data;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_bus = sda_m & ~SDA_oe;

  iic_slave_regbank #(.DEV_ADDR(7'h50), .DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .SCL(scl_m), .SDA_in(sda_bus), .SDA_out(SDA_out), .SDA_oe(SDA_oe),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_wr[$];
  logic [7:0]  exp_bus_val[$];
  string       exp_bus_name[$];
  logic [7:0]  obs_bus[$];

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Write-strobe monitor: every wr_valid pulse must match the next expected (addr,data).
  always @(negedge clk) begin : wr_mon
    logic [15:0] e;
    if (wr_valid === 1'b1) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wr_unexpected: got %h%h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        check("wr_pulse", {wr_addr, wr_data}, e);
        if (e[15:8] == rd_addr) check("rd_bypass", 16'(rd_data), 16'(e[7:0]));
      end
    end
  end

  // Bus monitor: compares what the master observed (ACK bits, read bytes) with expectations.
  always @(negedge clk) begin : bus_mon
    logic [7:0] o, e;
    string      nm;
    while (obs_bus.size() > 0) begin
      o = obs_bus.pop_front();
      if (exp_bus_val.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus_unexpected: got %h, expected no observation", o);
      end else begin
        e  = exp_bus_val.pop_front();
        nm = exp_bus_name.pop_front();
        check(nm, 16'(o), 16'(e));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_bus(string nm, logic [7:0] v);
    exp_bus_name.push_back(nm);
    exp_bus_val.push_back(v);
  endtask

  task automatic bus_start();
    if (!scl_m) begin
      tick(4); sda_m = 1'b1; tick(4); scl_m = 1'b1;
    end
    tick(8); sda_m = 1'b0; tick(8); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    tick(4); sda_m = 1'b0; tick(4); scl_m = 1'b1; tick(8); sda_m = 1'b1; tick(8);
  endtask

  task automatic put_bit(logic b);
    tick(4); sda_m = b; tick(4); scl_m = 1'b1; tick(8); scl_m = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    tick(4); sda_m = 1'b1; tick(4); scl_m = 1'b1; tick(4); b = sda_bus; tick(4); scl_m = 1'b0;
  endtask

  task automatic get_ack();
    logic b;
    get_bit(b);
    obs_bus.push_back({7'b0, ~b});
  endtask

  task automatic put_byte(logic [7:0] d);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_ack();
  endtask

  task automatic get_byte(logic ack);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    obs_bus.push_back(d);
    put_bit(~ack);
  endtask

  task automatic read_local(logic [7:0] a, logic [7:0] exp, string nm);
    rd_addr = a;
    tick(2);
    check(nm, 16'(rd_data), 16'(exp));
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: got still running at time limit, expected finished");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [7:0] dv;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = '0;
    tick(3);
    check("rst_sda_oe",   16'(SDA_oe),    16'd0);
    check("rst_sda_out",  16'(SDA_out),   16'd0);
    check("rst_wr_valid", 16'(wr_valid),  16'd0);
    check("rst_wr_addr",  16'(wr_addr),   16'd0);
    check("rst_wr_data",  16'(wr_data),   16'd0);
    check("rst_rd_data",  16'(rd_data),   16'd0);
    check("rst_state",    16'(dut.state), 16'd0);
    rst = 1'b0;
    tick(DEPTH + 8);
    read_local(8'h10, 8'h00, "clr_mem10");

    // Write 5A,3C from register 10; local read watches 10 to see the forwarded value.
    rd_addr = 8'h10;
    exp_wr.push_back(16'h105A);
    exp_wr.push_back(16'h113C);
    expect_bus("w_dev_ack", 8'h01); expect_bus("w_reg_ack", 8'h01);
    expect_bus("w_d0_ack", 8'h01);  expect_bus("w_d1_ack", 8'h01);
    bus_start(); put_byte(8'hA0); put_byte(8'h10); put_byte(8'h5A); put_byte(8'h3C); bus_stop();
    read_local(8'h11, 8'h3C, "w_mem11");
    read_local(8'h10, 8'h5A, "w_mem10");

    // Set pointer 10, repeated START, read two bytes (ACK then NACK).
    expect_bus("r_dev_ack", 8'h01); expect_bus("r_reg_ack", 8'h01); expect_bus("r_rdev_ack", 8'h01);
    expect_bus("r_byte0", 8'h5A);   expect_bus("r_byte1", 8'h3C);
    bus_start(); put_byte(8'hA0); put_byte(8'h10);
    bus_start(); put_byte(8'hA1); get_byte(1'b1); get_byte(1'b0); bus_stop();
    check("r_release", 16'(SDA_oe),    16'd0);
    check("r_idle",    16'(dut.state), 16'd0);

    // Wrong device address is refused and leaves the slave idle.
    expect_bus("nack_a2", 8'h00);
    bus_start(); put_byte(8'hA2);
    check("nack_idle", 16'(dut.state), 16'd0);
    check("nack_oe",   16'(SDA_oe),    16'd0);
    bus_stop();

    // Address-only write followed by a separate read starts at that address.
    expect_bus("p_dev_ack", 8'h01); expect_bus("p_reg_ack", 8'h01);
    expect_bus("p_rdev_ack", 8'h01); expect_bus("p_byte", 8'h3C);
    bus_start(); put_byte(8'hA0); put_byte(8'h11); bus_stop();
    bus_start(); put_byte(8'hA1); get_byte(1'b0); bus_stop();

    // Pointer wraps from FF to 00 during a burst write.
    exp_wr.push_back(16'hFF11);
    exp_wr.push_back(16'h0022);
    expect_bus("wrap_dev_ack", 8'h01); expect_bus("wrap_reg_ack", 8'h01);
    expect_bus("wrap_d0_ack", 8'h01);  expect_bus("wrap_d1_ack", 8'h01);
    bus_start(); put_byte(8'hA0); put_byte(8'hFF); put_byte(8'h11); put_byte(8'h22); bus_stop();
    read_local(8'hFF, 8'h11, "wrap_memff");
    read_local(8'h00, 8'h22, "wrap_mem00");

    // SCL held low mid-byte.
    dv = 8'hA0;
    bus_start();
    for (int i = 7; i >= 5; i--) put_bit(dv[i]);
`ifdef IIC_SLAVE_TIMEOUT_EN
    tick(90);
    check("to_not_yet", 16'(dut.state), 16'd1);
    tick(20);
    check("to_idle", 16'(dut.state), 16'd0);
    check("to_oe",   16'(SDA_oe),    16'd0);
    bus_stop();
    bus_start();
    expect_bus("stall_dev_ack", 8'h01);
    put_byte(dv);
`else
    tick(300);
    check("stall_hold", 16'(dut.state), 16'd1);
    for (int i = 4; i >= 0; i--) put_bit(dv[i]);
    expect_bus("stall_dev_ack", 8'h01);
    get_ack();
`endif
    exp_wr.push_back(16'h2077);
    expect_bus("stall_reg_ack", 8'h01); expect_bus("stall_d_ack", 8'h01);
    put_byte(8'h20); put_byte(8'h77); bus_stop();
    read_local(8'h20, 8'h77, "stall_mem20");

    // Reset while the slave is driving the address ACK.
    read_local(8'h10, 8'h5A, "pre_rst_mem10");
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(dv[i]);
    tick(4);
    check("ack_driven", 16'(SDA_oe), 16'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_release", 16'(SDA_oe), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(4); scl_m = 1'b1; tick(8); sda_m = 1'b1;
    tick(DEPTH + 8);
    read_local(8'h10, 8'h00, "post_rst_mem10");
    check("post_rst_idle", 16'(dut.state), 16'd0);

    tick(4);
    check("exp_wr_drained",  16'(exp_wr.size()),      16'd0);
    check("exp_bus_drained", 16'(exp_bus_val.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
